// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side blocks of the pipelined core:
// RAM handshake state, machine word, and arbiter FSM encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IGNT  = 2'd1,
    DGNT  = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts cycles an access has been outstanding and
// flags expiry when the count reaches TIMEOUT. TIMEOUT=0 disables it.
// Reusable by any grant/ACCESS style requester (arbiter, bus controller).
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,   // start of a new transaction
  input  logic run,     // transaction outstanding this cycle
  input  logic done,    // transaction completes this cycle
  output logic expire
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  // Count waiting cycles; hold at the limit so the count never wraps.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                        r_cnt <= '0;
    else if (clear)                   r_cnt <= '0;
    else if (run && !done && !expire) r_cnt <= r_cnt + 1'b1;
  end

  assign expire = (TIMEOUT != 0) && run && (r_cnt == W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between the I-cache (read-only) and D-cache
// (read/write). One grant at a time, held until RAM reports ACCESS, with a
// mandatory IDLE turnaround between transactions. A watchdog or a RAM ERROR
// drops the arbiter into a sticky FAULT that only nRST clears.
// Optional macro ARB_FAIR_EN: after FAIR_LIMIT data grants that bypassed a
// pending instruction fetch, the fetch is granted next. Without it, data
// requests have strict priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  arb_state_t r_state, w_next;
  logic       w_acc, w_rerr, w_grant, w_clear, w_expire, w_ifair;

  assign w_acc   = (ramstate == ACCESS);
  assign w_rerr  = (ramstate == ERROR);
  assign w_grant = (r_state == IGNT) || (r_state == DGNT);
  assign w_clear = (r_state == IDLE) && (w_next != IDLE);

  // Read data is a pass-through; the requester only samples it when its
  // wait signal drops.
  assign iload = ramload;
  assign dload = ramload;
  assign err   = (r_state == FAULT);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (w_clear),
    .run    (w_grant),
    .done   (w_acc),
    .expire (w_expire)
  );

`ifdef ARB_FAIR_EN
  localparam int FW = (FAIR_LIMIT < 2) ? 1 : $clog2(FAIR_LIMIT + 1);
  logic [FW-1:0] r_fcnt;

  assign w_ifair = iREN && (r_fcnt == FW'(FAIR_LIMIT));

  // Count data grants taken over a waiting fetch; a fetch grant resets it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                          r_fcnt <= '0;
    else if ((r_state == IDLE) && (w_next == IGNT))     r_fcnt <= '0;
    else if ((r_state == IDLE) && (w_next == DGNT) && iREN) r_fcnt <= r_fcnt + 1'b1;
  end
`else
  logic w_unused_fair;
  assign w_unused_fair = (FAIR_LIMIT == 0);
  assign w_ifair       = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and RAM/cache-side outputs; ACCESS beats watchdog expiry.
  always_comb begin
    w_next   = r_state;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      IDLE: begin
        if (w_ifair)          w_next = IGNT;
        else if (dREN | dWEN) w_next = DGNT;
        else if (iREN)        w_next = IGNT;
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (w_acc) begin
          iwait  = 1'b0;
          w_next = IDLE;
        end else if (w_rerr || w_expire) begin
          w_next = FAULT;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (w_acc) begin
          dwait  = 1'b0;
          w_next = IDLE;
        end else if (w_rerr || w_expire) begin
          w_next = FAULT;
        end
      end
      default: w_next = FAULT;
    endcase
  end

endmodule
